// File: rtl/wm8731_adc_rx.sv
// wm8731_adc_rx: WM8731 DSP-mode ADC deserializer to a valid/ready stereo register.
// Define WM8731_ADC_RX_PEAK_EN to add per-channel peak magnitude tracking.
module wm8731_adc_rx #(
  parameter int SAMPLE_W    = 16,
  parameter int DATA_DELAY  = 1,
  parameter int SYNC_STAGES = 2
) (
  input  logic                clk,
  input  logic                reset,
  input  logic                bclk,
  input  logic                adc_lrclk,
  input  logic                adc_dat,
  output logic [SAMPLE_W-1:0] out_left,
  output logic [SAMPLE_W-1:0] out_right,
  output logic                out_valid,
  input  logic                out_ready,
  output logic                overrun,
  output logic                frame_err,
  input  logic                err_clr
`ifdef WM8731_ADC_RX_PEAK_EN
  ,
  output logic [SAMPLE_W-2:0] peak_left,
  output logic [SAMPLE_W-2:0] peak_right,
  input  logic                peak_clr
`endif
);
  localparam int CW = $clog2(2 * SAMPLE_W + 1);
  localparam int DW = DATA_DELAY > 1 ? $clog2(DATA_DELAY + 1) : 1;
  localparam logic [1:0] IDLE = 2'd0, DELAY = 2'd1, LEFT = 2'd2, RIGHT = 2'd3;
  logic [2:0] sync_q [SYNC_STAGES];
  logic bclk_q, bit_edge, lrc, dat;
  logic [1:0] state;
  logic [CW-1:0] bcnt;
  logic [DW-1:0] dcnt;
  logic [SAMPLE_W-1:0] left_sr, right_next;
  logic [SAMPLE_W-2:0] right_sr;
  logic sync_hit, fe_set, done, shift_l, shift_r, load;
  always_ff @(posedge clk) begin
    if (reset) begin
      for (int i = 0; i < SYNC_STAGES; i++) sync_q[i] <= '0;
      bclk_q <= 1'b0;
    end else begin
      sync_q[0] <= {bclk, adc_lrclk, adc_dat};
      for (int i = 1; i < SYNC_STAGES; i++) sync_q[i] <= sync_q[i-1];
      bclk_q <= sync_q[SYNC_STAGES-1][2];
    end
  end
  always_comb begin
    bit_edge   = sync_q[SYNC_STAGES-1][2] & ~bclk_q;
    lrc        = sync_q[SYNC_STAGES-1][1];
    dat        = sync_q[SYNC_STAGES-1][0];
    sync_hit   = bit_edge & lrc;
    fe_set     = sync_hit & (state != IDLE);
    done       = bit_edge & ~lrc & (state == RIGHT) & (bcnt == CW'(2 * SAMPLE_W - 1));
    shift_l    = (bit_edge & ~lrc & ((state == LEFT) | ((state == DELAY) & (dcnt == DW'(1)))))
               | ((DATA_DELAY == 0) & sync_hit);
    shift_r    = bit_edge & ~lrc & (state == RIGHT);
    right_next = {right_sr, dat};
    load       = done & (~out_valid | out_ready);
  end
  // A sync edge in any state (re)starts a frame; outside IDLE it is also a frame error.
  always_ff @(posedge clk) begin
    if (reset) begin
      state    <= IDLE;
      bcnt     <= '0;
      dcnt     <= '0;
      left_sr  <= '0;
      right_sr <= '0;
    end else begin
      if (bit_edge) begin
        if (lrc) begin
          state <= DATA_DELAY == 0 ? LEFT : DELAY;
          dcnt  <= DW'(DATA_DELAY);
          bcnt  <= DATA_DELAY == 0 ? CW'(1) : '0;
        end else if (state == DELAY) begin
          dcnt <= dcnt - DW'(1);
          if (dcnt == DW'(1)) begin
            state <= LEFT;
            bcnt  <= CW'(1);
          end
        end else if (state != IDLE) begin
          bcnt <= bcnt + CW'(1);
          if (bcnt == CW'(SAMPLE_W - 1)) state <= RIGHT;
          if (done) state <= IDLE;
        end
      end
      if (shift_l) left_sr <= {left_sr[SAMPLE_W-2:0], dat};
      if (shift_r) right_sr <= right_next[SAMPLE_W-2:0];
    end
  end
  always_ff @(posedge clk) begin
    if (reset) begin
      out_left  <= '0;
      out_right <= '0;
      out_valid <= 1'b0;
      overrun   <= 1'b0;
      frame_err <= 1'b0;
    end else begin
      out_valid <= load | (out_valid & ~out_ready);
      if (load) begin
        out_left  <= left_sr;
        out_right <= right_next;
      end
      overrun   <= (done & ~load) | (overrun & ~err_clr);
      frame_err <= fe_set | (frame_err & ~err_clr);
    end
  end
`ifdef WM8731_ADC_RX_PEAK_EN
  function automatic logic [SAMPLE_W-2:0] mag(input logic [SAMPLE_W-1:0] s);
    logic [SAMPLE_W-1:0] n;
    n = -s;
    return s[SAMPLE_W-1] ? (n[SAMPLE_W-1] ? '1 : n[SAMPLE_W-2:0]) : s[SAMPLE_W-2:0];
  endfunction
  logic [SAMPLE_W-2:0] mag_l, mag_r;
  always_comb begin
    mag_l = mag(left_sr);
    mag_r = mag(right_next);
  end
  always_ff @(posedge clk) begin
    if (reset) begin
      peak_left  <= '0;
      peak_right <= '0;
    end else begin
      peak_left  <= peak_clr ? (load ? mag_l : '0) : (load && mag_l > peak_left) ? mag_l : peak_left;
      peak_right <= peak_clr ? (load ? mag_r : '0) : (load && mag_r > peak_right) ? mag_r : peak_right;
    end
  end
`endif
endmodule

// File: tb/tb_wm8731_adc_rx.sv
// tb_wm8731_adc_rx: scoreboard bench for wm8731_adc_rx (DATA_DELAY=1 and DATA_DELAY=0 instances).
`timescale 1ns/1ps
module tb_wm8731_adc_rx;
  typedef struct packed {logic [15:0] l; logic [15:0] r;} pair_t;
  logic clk = 1'b0, reset = 1'b1, bclk = 1'b0, lrc = 1'b0, dat = 1'b0;
  logic rdy = 1'b1, err_clr = 1'b0, chk0 = 1'b0;
  logic [15:0] l1, r1, l0, r0;
  logic v1, v0, ovr1, ovr0, fe1, fe0;
  pair_t q1[$], q0[$];
  int tests = 0, fails = 0;
`ifdef WM8731_ADC_RX_PEAK_EN
  logic peak_clr = 1'b0;
  logic [14:0] pk_l1, pk_r1, pk_l0, pk_r0;
`endif
  always #10 clk = ~clk;

  wm8731_adc_rx #(.SAMPLE_W(16), .DATA_DELAY(1), .SYNC_STAGES(2)) dut (
    .clk(clk), .reset(reset), .bclk(bclk), .adc_lrclk(lrc), .adc_dat(dat),
    .out_left(l1), .out_right(r1), .out_valid(v1), .out_ready(rdy),
    .overrun(ovr1), .frame_err(fe1), .err_clr(err_clr)
`ifdef WM8731_ADC_RX_PEAK_EN
    , .peak_left(pk_l1), .peak_right(pk_r1), .peak_clr(peak_clr)
`endif
  );

  wm8731_adc_rx #(.SAMPLE_W(16), .DATA_DELAY(0), .SYNC_STAGES(2)) dut0 (
    .clk(clk), .reset(reset), .bclk(bclk), .adc_lrclk(lrc), .adc_dat(dat),
    .out_left(l0), .out_right(r0), .out_valid(v0), .out_ready(1'b1),
    .overrun(ovr0), .frame_err(fe0), .err_clr(err_clr)
`ifdef WM8731_ADC_RX_PEAK_EN
    , .peak_left(pk_l0), .peak_right(pk_r0), .peak_clr(peak_clr)
`endif
  );

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  task automatic bit_out(input logic lr, input logic d);
    lrc = lr;
    dat = d;
    #160 bclk = 1'b1;
    #160 bclk = 1'b0;
  endtask

  // DATA_DELAY=1 framing: sync edge carries no data, MSB on the next edge
  task automatic frame(input logic [15:0] l, input logic [15:0] r, input int nb);
    logic [31:0] w;
    w = {l, r};
    bit_out(1'b1, 1'b0);
    for (int i = 0; i < nb; i++) bit_out(1'b0, w[31-i]);
  endtask

  // DATA_DELAY=0 framing: MSB on the sync edge
  task automatic frame0(input logic [15:0] l, input logic [15:0] r);
    logic [31:0] w;
    w = {l, r};
    bit_out(1'b1, w[31]);
    for (int i = 1; i < 32; i++) bit_out(1'b0, w[31-i]);
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) bit_out(1'b0, 1'b0);
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  always @(negedge clk) begin
    if (!reset && v1 && rdy) begin
      if (q1.size() == 0) begin
        tests++;
        fails++;
        $display("FAIL pair1: unexpected pair %h/%h", l1, r1);
      end else begin
        pair_t e;
        e = q1.pop_front();
        check("pair1", {l1, r1}, {e.l, e.r});
      end
    end
    if (!reset && chk0 && v0) begin
      if (q0.size() == 0) begin
        tests++;
        fails++;
        $display("FAIL pair0: unexpected pair %h/%h", l0, r0);
      end else begin
        pair_t e;
        e = q0.pop_front();
        check("pair0", {l0, r0}, {e.l, e.r});
      end
    end
  end

  initial begin
    repeat (3) @(posedge clk);
    #1;
    check("rst_valid", 32'(v1), 32'd0);
    check("rst_left", 32'(l1), 32'd0);
    check("rst_right", 32'(r1), 32'd0);
    check("rst_overrun", 32'(ovr1), 32'd0);
    check("rst_frame_err", 32'(fe1), 32'd0);
    reset = 1'b0;
    tick();
`ifdef WM8731_ADC_RX_PEAK_EN
    q1.push_back('{16'h0100, 16'hFF00});
    frame(16'h0100, 16'hFF00, 32);
    idle(2);
    q1.push_back('{16'h8000, 16'h0010});
    frame(16'h8000, 16'h0010, 32);
    idle(2);
    check("peak_left", 32'(pk_l1), 32'h7FFF);
    check("peak_right", 32'(pk_r1), 32'h0100);
    peak_clr = 1'b1;
    tick();
    peak_clr = 1'b0;
    tick();
    check("peak_clr_left", 32'(pk_l1), 32'd0);
    check("peak_clr_right", 32'(pk_r1), 32'd0);
`endif
    q1.push_back('{16'hA5C3, 16'h7F01});
    frame(16'hA5C3, 16'h7F01, 32);
    idle(2);
    check("rx_overrun", 32'(ovr1), 32'd0);
    check("rx_frame_err", 32'(fe1), 32'd0);

    rdy = 1'b0;
    q1.push_back('{16'h1234, 16'h5678});
    frame(16'h1234, 16'h5678, 32);
    idle(2);
    frame(16'h9ABC, 16'hDEF0, 32);
    idle(2);
    check("bp_hold", {l1, r1}, 32'h1234_5678);
    check("bp_valid", 32'(v1), 32'd1);
    check("bp_overrun", 32'(ovr1), 32'd1);
    err_clr = 1'b1;
    rdy = 1'b1;
    tick();
    err_clr = 1'b0;
    tick();
    check("bp_clr_overrun", 32'(ovr1), 32'd0);
    check("bp_drained", 32'(v1), 32'd0);

    frame(16'hFFFF, 16'hFFFF, 10);
    q1.push_back('{16'h0001, 16'h0002});
    frame(16'h0001, 16'h0002, 32);
    idle(2);
    check("early_frame_err", 32'(fe1), 32'd1);
    err_clr = 1'b1;
    tick();
    err_clr = 1'b0;
    tick();
    check("early_clr", 32'(fe1), 32'd0);

    frame(16'h1111, 16'h2222, 21);
    reset = 1'b1;
    tick();
    tick();
    check("mid_rst_left", 32'(l1), 32'd0);
    check("mid_rst_right", 32'(r1), 32'd0);
    check("mid_rst_valid", 32'(v1), 32'd0);
    reset = 1'b0;
    tick();
    idle(2);
    check("mid_rst_no_valid", 32'(v1), 32'd0);
    q1.push_back('{16'h0F0F, 16'hF0F0});
    frame(16'h0F0F, 16'hF0F0, 32);
    idle(2);
    check("mid_rst_frame_err", 32'(fe1), 32'd0);

    chk0 = 1'b1;
    q0.push_back('{16'h8000, 16'hFFFF});
    q1.push_back('{16'h0001, 16'hFFFE});
    frame0(16'h8000, 16'hFFFF);
    idle(3);

    check("q1_drained", 32'(q1.size()), 32'd0);
    check("q0_drained", 32'(q0.size()), 32'd0);
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
endmodule
